// File: rtl/memory_responder.sv
// Multi-cycle unified instruction/data memory answering mem_read/mem_write after LATENCY cycles.
// Optional feature: define MISALIGN_CHECK_EN to flag and suppress accesses with addr[1:0] != 0.
module memory_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] mem_dout,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

`ifdef MISALIGN_CHECK_EN
    localparam bit MISALIGN_CHECK = 1'b1;
`else
    localparam bit MISALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic                op_write_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic                cap_en_c;
    logic                access_c;
    logic                misalign_c;
    logic                ready_n, busy_n, err_n;
    logic [ADDR_W-1:0]   word_c;
    logic                unused_addr_c;

    logic [DATA_W-1:0]   mem_array [DEPTH];

    // Upper address bits wrap away; they never select a word.
    assign unused_addr_c = ^addr[31:ADDR_W+2];
    assign word_c        = addr_q[ADDR_W+1:2];
    assign misalign_c    = MISALIGN_CHECK && (addr_q[1:0] != 2'b00);

    // Next-state, counter and next-output decode.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        cap_en_c = 1'b0;
        access_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    cap_en_c = 1'b1;
                    cnt_n    = CNT_W'(LATENCY - 1);
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else begin
                    access_c = 1'b1;
                    state_n  = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == RESP);
        busy_n  = (state_n != IDLE);
        err_n   = access_c && misalign_c;
    end

    // State, counter, request capture and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            mem_dout   <= '0;
            mem_ready  <= 1'b0;
            mem_busy   <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            mem_ready <= ready_n;
            mem_busy  <= busy_n;
            mem_err   <= err_n;
            if (cap_en_c) begin
                op_write_q <= mem_write;
                addr_q     <= addr[ADDR_W+1:0];
                din_q      <= din;
            end
            if (access_c) begin
                if (misalign_c) begin
                    mem_dout <= '0;
                end else if (!op_write_q) begin
                    mem_dout <= mem_array[word_c];
                end
            end
        end
    end

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (access_c && op_write_q && !misalign_c) begin
            mem_array[word_c] <= din_q;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Randomized self-checking bench for memory_responder against an array-based reference model.
// Honours MISALIGN_CHECK_EN the same way the design does.
module tb_memory_responder;

    localparam int unsigned LATENCY = 4;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

`ifdef MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, din, mem_dout;
    logic        mem_ready, mem_busy, mem_err;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    int          written_q[$];
    logic [31:0] exp_dout;

    memory_responder #(.LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .din      (din),
        .mem_dout (mem_dout),
        .mem_ready(mem_ready),
        .mem_busy (mem_busy),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete request: issue, scramble inputs after capture, await mem_ready, verify.
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int n;
        int w;
        bit mis;
        @(negedge clk);
        mem_write = wr;
        mem_read  = rd;
        addr      = a;
        din       = d;
        @(negedge clk);
        check("busy_rise", 32'(mem_busy), 32'd1);
        check("ready_early", 32'(mem_ready), 32'd0);
        addr = $urandom;
        din  = $urandom;
        n = 1;
        while (!mem_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        w   = int'(a[ADDR_W+1:2]);
        mis = CHK && (a[1:0] != 2'b00);
        if (mis) begin
            exp_dout = 32'd0;
        end else if (wr) begin
            model[w] = d;
            if (!known[w]) written_q.push_back(w);
            known[w] = 1'b1;
        end else begin
            exp_dout = model[w];
        end
        if (!mem_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(n), 32'(LATENCY + 1));
            check("busy_resp", 32'(mem_busy), 32'd1);
            check("dout", mem_dout, exp_dout);
            check("err", 32'(mem_err), 32'(mis));
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        check("ready_pulse", 32'(mem_ready), 32'd0);
        check("busy_idle", 32'(mem_busy), 32'd0);
        check("err_idle", 32'(mem_err), 32'd0);
        check("dout_hold", mem_dout, exp_dout);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout"}, mem_dout, 32'd0);
        check({tag, "_ready"}, 32'(mem_ready), 32'd0);
        check({tag, "_busy"}, 32'(mem_busy), 32'd0);
        check({tag, "_err"}, 32'(mem_err), 32'd0);
    endtask

    initial begin
        bit          saw_ready;
        logic [31:0] a;
        int          w;
        int          r;

        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        din       = '0;
        exp_dout  = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Directed scenarios
        do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 32'h10, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("dout_idle", mem_dout, 32'hDEADBEEF);
        end
        do_req(1'b1, 1'b1, 32'h20, 32'h12345678);
        do_req(1'b0, 1'b1, 32'h20, 32'h0);
        do_req(1'b1, 1'b0, 32'h1004, 32'hA5A5A5A5);
        do_req(1'b0, 1'b1, 32'h0004, 32'h0);
        do_req(1'b0, 1'b1, 32'h13, 32'h0);

        // Reset two cycles into a write aborts it
        do_req(1'b1, 1'b0, 32'h08, 32'h11111111);
        @(negedge clk);
        mem_write = 1'b1;
        addr      = 32'h08;
        din       = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        mem_write = 1'b0;
        exp_dout  = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        saw_ready = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (mem_ready) saw_ready = 1'b1;
        end
        check("abort_no_ready", 32'(saw_ready), 32'd0);
        do_req(1'b0, 1'b1, 32'h08, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (r <= 1 && written_q.size() > 0) begin
                w = written_q[$urandom_range(0, written_q.size() - 1)];
                a[ADDR_W+1:2] = ADDR_W'(w);
                do_req(1'b0, 1'b1, a, 32'h0);
            end else begin
                do_req(1'b1, (r == 3), a, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
